// File: rtl/sram_controller.sv
// Bridges a 32-bit load/store port onto a 16-bit asynchronous SRAM as two half-word accesses.
// Latency 3+WAIT_CYCLES cycles from request. ready stays low until DONE so the pipeline stalls.
module sram_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_out,
  input  logic [15:0] SRAM_DQ_in,
  output logic        SRAM_DQ_oe,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ACC_LO = 3'd1;
  localparam logic [2:0] ACC_HI = 3'd2;
  localparam logic [2:0] WAIT   = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  logic [2:0]  state;
  logic [3:0]  wait_cnt;
  logic [16:0] lat_word;
  logic [31:0] lat_data;
  logic        lat_wr;
  logic        req;
  logic [31:0] addr_off;
  logic        unused_addr_bits;

  assign req      = rd_en | wr_en;
  assign addr_off = address - 32'(BASE_ADDR);
  // Only word-index bits 18:2 reach the 18-bit half-word bus.
  assign unused_addr_bits = ^{addr_off[31:19], addr_off[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      lat_word  <= '0;
      lat_data  <= '0;
      lat_wr    <= 1'b0;
      read_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state    <= ACC_LO;
            lat_word <= addr_off[18:2];
            lat_data <= write_data;
            lat_wr   <= wr_en;
          end
        end
        ACC_LO: begin
          state <= ACC_HI;
          if (!lat_wr) read_data[15:0] <= SRAM_DQ_in;
        end
        ACC_HI: begin
          if (!lat_wr) read_data[31:16] <= SRAM_DQ_in;
          wait_cnt <= WAIT_LD;
          state    <= (WAIT_CYCLES > 0) ? WAIT : DONE;
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt <= 4'd1) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    SRAM_ADDR   = '0;
    SRAM_DQ_out = '0;
    SRAM_DQ_oe  = 1'b0;
    SRAM_WE_N   = 1'b1;
    SRAM_OE_N   = 1'b1;
    if (state == ACC_LO || state == ACC_HI) begin
      SRAM_ADDR  = {lat_word, state == ACC_HI};
      SRAM_WE_N  = ~lat_wr;
      SRAM_OE_N  = lat_wr;
      SRAM_DQ_oe = lat_wr;
      if (lat_wr) SRAM_DQ_out = (state == ACC_HI) ? lat_data[31:16] : lat_data[15:0];
    end
  end

  assign ready = ~req | (state == DONE);

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: a word-level memory model, a vector table, randomized loads and stores,
// and hand-written reset, back-to-back and zero-wait sequences.
module tb_sram_controller;

  logic        clk;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] dq_out, dq_in;
  logic        dq_oe, we_n, oe_n;

  logic        rd_en0, wr_en0;
  logic [31:0] address0, write_data0, read_data0;
  logic        ready0;
  logic [17:0] sram_addr0;
  logic [15:0] dq_out0, dq_in0;
  logic        dq_oe0, we_n0, oe_n0;

  logic [15:0] mem  [1024];
  logic [15:0] mem0 [1024];
  logic [31:0] ref_w [512];
  logic [31:0] ref_rd;

  int errors = 0;
  int checks = 0;

  sram_controller dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready), .SRAM_ADDR(sram_addr),
    .SRAM_DQ_out(dq_out), .SRAM_DQ_in(dq_in), .SRAM_DQ_oe(dq_oe), .SRAM_WE_N(we_n),
    .SRAM_OE_N(oe_n)
  );

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .rd_en(rd_en0), .wr_en(wr_en0), .address(address0),
    .write_data(write_data0), .read_data(read_data0), .ready(ready0), .SRAM_ADDR(sram_addr0),
    .SRAM_DQ_out(dq_out0), .SRAM_DQ_in(dq_in0), .SRAM_DQ_oe(dq_oe0), .SRAM_WE_N(we_n0),
    .SRAM_OE_N(oe_n0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] seed_word(input int wi);
    return (32'(wi) + 32'd1) * 32'h9E3779B1 ^ 32'h5BD1E995;
  endfunction

  // Asynchronous SRAM: combinational read while OE_N low, write on the edge that ends a WE_N-low cycle.
  assign dq_in  = oe_n  ? 16'h5A5A : mem[sram_addr[9:0]];
  assign dq_in0 = oe_n0 ? 16'h5A5A : mem0[sram_addr0[9:0]];

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[2*i]   = seed_word(i) & 32'hFFFF;
      mem[2*i+1] = seed_word(i) >> 16;
    end
    for (int i = 0; i < 1024; i++) mem0[i] = 16'h0;
    mem0[2] = 16'hBEEF;
    mem0[3] = 16'hDEAD;
    forever begin
      @(posedge clk);
      if (!we_n)  mem[sram_addr[9:0]]   = dq_out;
      if (!we_n0) mem0[sram_addr0[9:0]] = dq_out0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Starts just after a rising edge with the DUT idle; ends the same way.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic use_tab, input logic [31:0] tab_rd, input string nm);
    int wi, lat;
    logic [31:0] exp_rd;
    wi = int'((a - 32'd1024) / 32'd4);
    if (wr) ref_w[wi] = d;
    else    ref_rd    = ref_w[wi];
    exp_rd = ref_rd;
    rd_en = rd; wr_en = wr; address = a; write_data = d;
    lat = -1;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1 || c == 2) begin
        chk({nm, " addr"}, 32'(sram_addr), 32'(2*wi + c - 1));
        chk({nm, " we_n"}, 32'(we_n), 32'(!wr));
        chk({nm, " oe_n"}, 32'(oe_n), 32'(wr));
        chk({nm, " dq_oe"}, 32'(dq_oe), 32'(wr));
        if (wr) chk({nm, " dq_out"}, 32'(dq_out), 32'((c == 1) ? d[15:0] : d[31:16]));
      end
      if (ready) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
      if (c == 0) begin
        address    = $urandom;
        write_data = $urandom;
      end
    end
    chk({nm, " latency"}, 32'(lat), 32'd6);
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    chk({nm, " read_data"}, read_data, exp_rd);
    if (use_tab) chk({nm, " table read_data"}, read_data, tab_rd);
    chk({nm, " ready idle"}, 32'(ready), 32'd1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int lat, k, sel;
    logic [31:0] d;

    vecs[0] = '{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 32'd1032, 32'h12345678, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b1, 32'd1036, 32'hCAFEF00D, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 1'b0, 32'd1036, 32'h0,        32'hCAFEF00D};
    vecs[5] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'h12345678};

    for (int i = 0; i < 512; i++) ref_w[i] = seed_word(i);
    ref_rd = 32'h0;
    rst = 1'b0;
    rd_en = 0; wr_en = 0; address = 0; write_data = 0;
    rd_en0 = 0; wr_en0 = 0; address0 = 0; write_data0 = 0;

    #1;
    chk("reset ready", 32'(ready), 32'd1);
    chk("reset we_n", 32'(we_n), 32'd1);
    chk("reset oe_n", 32'(oe_n), 32'd1);
    chk("reset dq_oe", 32'(dq_oe), 32'd0);
    chk("reset addr", 32'(sram_addr), 32'd0);
    chk("reset read_data", read_data, 32'd0);

    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("idle ready", 32'(ready), 32'd1);
      chk("idle we_n", 32'(we_n), 32'd1);
      chk("idle oe_n", 32'(oe_n), 32'd1);
      chk("idle dq_oe", 32'(dq_oe), 32'd0);
    end
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++)
      run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b1, vecs[i].exp_rd,
              $sformatf("vec%0d", i));

    // Back-to-back stores: request held through DONE, address changed for the second one.
    wr_en = 1'b1; address = 32'd1024; write_data = 32'hA5A50001;
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      chk($sformatf("b2b addr c%0d", c), 32'(sram_addr),
          (c == 2) ? 32'd1 : (c == 8) ? 32'd4 : (c == 9) ? 32'd5 : 32'd0);
      chk($sformatf("b2b we_n c%0d", c), 32'(we_n),
          (c == 1 || c == 2 || c == 8 || c == 9) ? 32'd0 : 32'd1);
      chk($sformatf("b2b ready c%0d", c), 32'(ready), (c == 6 || c == 13) ? 32'd1 : 32'd0);
      if (c == 9) chk("b2b dq_out hi", 32'(dq_out), 32'h5A5A);
      @(posedge clk); #1;
      if (c == 6) begin
        address = 32'd1032; write_data = 32'h5A5A0002;
      end
    end
    wr_en = 1'b0;
    ref_w[0] = 32'hA5A50001;
    ref_w[2] = 32'h5A5A0002;
    run_txn(1'b1, 1'b0, 32'd1032, 32'h0, 1'b1, 32'h5A5A0002, "b2b readback");

    for (int i = 0; i < 40; i++) begin
      k   = $urandom_range(0, 15);
      sel = $urandom_range(0, 2);
      run_txn(sel != 1, sel != 0, 32'd1024 + 32'(4*k), $urandom, 1'b0, 32'h0,
              $sformatf("rand%0d", i));
    end

    // Reset during ACC_HI of a store: only the low half reaches the SRAM.
    d = 32'h11223344;
    wr_en = 1'b1; address = 32'd1104; write_data = d;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst pre we_n", 32'(we_n), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("rst we_n", 32'(we_n), 32'd1);
    chk("rst oe_n", 32'(oe_n), 32'd1);
    chk("rst dq_oe", 32'(dq_oe), 32'd0);
    chk("rst addr", 32'(sram_addr), 32'd0);
    chk("rst ready req", 32'(ready), 32'd0);
    chk("rst read_data", read_data, 32'd0);
    wr_en = 1'b0;
    #1;
    chk("rst ready noreq", 32'(ready), 32'd1);
    ref_rd = 32'h0;
    ref_w[20][15:0] = d[15:0];
    @(posedge clk); #1;
    chk("rst held we_n", 32'(we_n), 32'd1);
    rst = 1'b1;
    run_txn(1'b1, 1'b0, 32'd1104, 32'h0, 1'b0, 32'h0, "post-rst read");

    // Zero wait cycles: read then a dual-enable request on the second instance.
    rd_en0 = 1'b1; address0 = 32'd1028;
    lat = -1;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      if (ready0) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    chk("w0 read latency", 32'(lat), 32'd3);
    @(posedge clk); #1;
    rd_en0 = 1'b0;
    @(negedge clk);
    chk("w0 read_data", read_data0, 32'hDEADBEEF);
    @(posedge clk); #1;

    rd_en0 = 1'b1; wr_en0 = 1'b1; address0 = 32'd1032; write_data0 = 32'h0BADCAFE;
    lat = -1;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1 || c == 2) begin
        chk("w0 both oe_n", 32'(oe_n0), 32'd1);
        chk("w0 both we_n", 32'(we_n0), 32'd0);
      end
      if (ready0) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    chk("w0 write latency", 32'(lat), 32'd3);
    @(posedge clk); #1;
    rd_en0 = 1'b0; wr_en0 = 1'b0;
    @(negedge clk);
    chk("w0 mem lo", 32'(mem0[4]), 32'hCAFE);
    chk("w0 mem hi", 32'(mem0[5]), 32'h0BAD);
    chk("w0 read_data kept", read_data0, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
